// File: rtl/nsc_byte_push_arbiter.sv
// nsc_byte_push_arbiter: round-robin arbiter admitting whole even-length byte bursts
// from two requesters into the shared 9-bit push port of the dual-clock FIFO.
module nsc_byte_push_arbiter #(
    parameter int DepthBytes = 128,
    parameter int LenWidth   = 5
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic                          iReq0Valid,
    input  logic                          iReq1Valid,
    input  logic [LenWidth-1:0]           iReq0Length,
    input  logic [LenWidth-1:0]           iReq1Length,
    output logic [1:0]                    oReqGrant,
    input  logic [8:0]                    iReq0Data,
    input  logic [8:0]                    iReq1Data,
    input  logic                          iReq0DataValid,
    input  logic                          iReq1DataValid,
    output logic                          oReq0DataReady,
    output logic                          oReq1DataReady,
    output logic [8:0]                    oPushData,
    output logic                          oPushEnable,
    input  logic                          iFifoFull,
    input  logic [$clog2(DepthBytes)-1:0] iFifoDataCount,
    output logic                          oBusy,
    output logic                          oActiveId
);
    localparam int CntW = $clog2(DepthBytes);

    typedef enum logic [1:0] {IDLE, GRANT, STREAM, SETTLE} state_t;

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                id_q, id_d;
    logic [LenWidth-1:0] rem_q, rem_d;
    logic                settle_q, settle_d;
    logic [1:0]          grant_q, grant_d;
    logic                busy_q, busy_d;

    logic                cand, cand_valid, fits, streaming, ready, sel_valid;
    logic [LenWidth-1:0] cand_len, eff_len;
    logic [CntW:0]       free;
    logic [8:0]          sel_data;

    always_comb begin
        cand       = (iReq0Valid && iReq1Valid) ? ptr_q : iReq1Valid;
        cand_valid = iReq0Valid || iReq1Valid;
        cand_len   = cand ? iReq1Length : iReq0Length;
        eff_len    = cand_len & ~LenWidth'(1);
        // the top count value is treated as possibly full, hence Depth-1
        free       = (CntW+1)'(DepthBytes - 1) - (CntW+1)'(iFifoDataCount);
        fits       = free >= (CntW+1)'(eff_len);
        streaming  = state_q == STREAM;
        ready      = streaming && !iFifoFull;
        sel_valid  = id_q ? iReq1DataValid : iReq0DataValid;
        sel_data   = id_q ? iReq1Data : iReq0Data;
    end

    assign oReq0DataReady = ready && !id_q;
    assign oReq1DataReady = ready && id_q;
    assign oPushEnable    = ready && sel_valid;
    assign oPushData      = streaming ? sel_data : '0;
    assign oReqGrant      = grant_q;
    assign oBusy          = busy_q;
    assign oActiveId      = id_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        rem_d    = rem_q;
        settle_d = settle_q;
        grant_d  = '0;
        busy_d   = busy_q;
        unique case (state_q)
            IDLE: begin
                if (cand_valid && fits) begin
                    state_d = GRANT;
                    id_d    = cand;
                    ptr_d   = ~cand;
                    rem_d   = eff_len;
                    grant_d = cand ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                state_d = (rem_q == '0) ? IDLE : STREAM;
                busy_d  = rem_q != '0;
            end
            STREAM: begin
                if (oPushEnable) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LenWidth'(1)) begin
                        state_d  = SETTLE;
                        settle_d = 1'b0;
                    end
                end
            end
            SETTLE: begin
                settle_d = 1'b1;
                if (settle_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            rem_q    <= '0;
            settle_q <= 1'b0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            rem_q    <= rem_d;
            settle_q <= settle_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end
endmodule

// File: tb/tb_nsc_byte_push_arbiter.sv
// tb_nsc_byte_push_arbiter: directed bench with a behavioural FIFO occupancy model
// and per-requester byte sources that advance on accepted beats.
module tb_nsc_byte_push_arbiter;
    logic       iClock = 1'b0;
    logic       iReset = 1'b0;
    logic       iReq0Valid = 1'b0, iReq1Valid = 1'b0;
    logic [4:0] iReq0Length = '0, iReq1Length = '0;
    logic [1:0] oReqGrant;
    logic [8:0] iReq0Data = '0, iReq1Data = '0;
    logic       iReq0DataValid = 1'b0, iReq1DataValid = 1'b0;
    logic       oReq0DataReady, oReq1DataReady;
    logic [8:0] oPushData;
    logic       oPushEnable;
    logic       iFifoFull = 1'b0;
    logic [6:0] iFifoDataCount = '0;
    logic       oBusy, oActiveId;

    int checks = 0, failures = 0;

    int         cnt = 0, cnt_set = -1, pops = 0, idx0 = 0, idx1 = 0;
    logic [8:0] base0 = '0, base1 = '0;
    logic       dv0 = 1'b0, dv1 = 1'b0, force_full = 1'b0;
    logic       pend_push = 1'b0, pend_acc0 = 1'b0, pend_acc1 = 1'b0;
    logic [8:0] pend_data = '0;
    logic [8:0] pushq[$];

    always #5 iClock = ~iClock;

    nsc_byte_push_arbiter dut (
        .iClock(iClock), .iReset(iReset),
        .iReq0Valid(iReq0Valid), .iReq1Valid(iReq1Valid),
        .iReq0Length(iReq0Length), .iReq1Length(iReq1Length),
        .oReqGrant(oReqGrant),
        .iReq0Data(iReq0Data), .iReq1Data(iReq1Data),
        .iReq0DataValid(iReq0DataValid), .iReq1DataValid(iReq1DataValid),
        .oReq0DataReady(oReq0DataReady), .oReq1DataReady(oReq1DataReady),
        .oPushData(oPushData), .oPushEnable(oPushEnable),
        .iFifoFull(iFifoFull), .iFifoDataCount(iFifoDataCount),
        .oBusy(oBusy), .oActiveId(oActiveId)
    );

    // FIFO and source model: commit last cycle's handshakes, then drive this cycle
    initial forever begin
        @(negedge iClock);
        if (pend_push) begin
            pushq.push_back(pend_data);
            cnt++;
        end
        if (pend_acc0) idx0++;
        if (pend_acc1) idx1++;
        if (cnt_set >= 0) begin
            cnt = cnt_set;
            cnt_set = -1;
        end
        if (pops > 0 && cnt >= 2) begin
            cnt -= 2;
            pops--;
        end
        iFifoDataCount = 7'(cnt);
        iFifoFull      = force_full || cnt >= 127;
        iReq0Data      = base0 + 9'(idx0);
        iReq1Data      = base1 + 9'(idx1);
        iReq0DataValid = dv0;
        iReq1DataValid = dv1;
        #1;
        pend_push = oPushEnable;
        pend_data = oPushData;
        pend_acc0 = oReq0DataReady && iReq0DataValid;
        pend_acc1 = oReq1DataReady && iReq1DataValid;
    end

    task automatic tick();
        @(negedge iClock);
        #2;
    endtask

    task automatic reset_model(input int c);
        cnt_set = c;
        pushq.delete();
        idx0 = 0;
        idx1 = 0;
        pend_push = 1'b0;
        pend_acc0 = 1'b0;
        pend_acc1 = 1'b0;
        dv0 = 1'b0;
        dv1 = 1'b0;
    endtask

    task automatic do_reset();
        iReset = 1'b0;
        tick();
        iReset = 1'b1;
        reset_model(0);
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (oReqGrant !== 2'b00 || oReq0DataReady !== 1'b0 || oReq1DataReady !== 1'b0 ||
            oPushEnable !== 1'b0 || oPushData !== 9'h000 || oBusy !== 1'b0 || oActiveId !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: grant=%b rdy=%b%b push=%b data=%h busy=%b id=%b required all zero",
                     oReqGrant, oReq1DataReady, oReq0DataReady, oPushEnable, oPushData, oBusy, oActiveId);
        end
        iReset = 1'b1;
        tick();
        tick();
        checks++;
        if (oBusy !== 1'b0 || oReqGrant !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_release: busy=%b grant=%b required 0/00", oBusy, oReqGrant);
        end
    endtask

    task automatic test_single_burst();
        base0 = 9'h010;
        dv0 = 1'b1;
        iReq0Valid = 1'b1;
        iReq0Length = 5'd8;
        tick();
        checks++;
        if (oReqGrant !== 2'b01 || oBusy !== 1'b1 || oReq0DataReady !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: grant=%b busy=%b rdy0=%b required 01/1/0", oReqGrant, oBusy, oReq0DataReady);
        end
        iReq0Valid = 1'b0;
        tick();
        checks++;
        if (oReqGrant !== 2'b00 || oReq0DataReady !== 1'b1) begin
            failures++;
            $display("FAIL single_first_ready: grant=%b rdy0=%b required 00/1", oReqGrant, oReq0DataReady);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (oPushEnable !== 1'b1 || oPushData !== 9'h010 + 9'(i)) begin
                failures++;
                $display("FAIL single_push%0d: en=%b data=%h required 1/%h", i, oPushEnable, oPushData, 9'h010 + 9'(i));
            end
            tick();
        end
        checks++;
        if (oPushEnable !== 1'b0 || oBusy !== 1'b1) begin
            failures++;
            $display("FAIL single_settle1: en=%b busy=%b required 0/1", oPushEnable, oBusy);
        end
        tick();
        checks++;
        if (oBusy !== 1'b1) begin
            failures++;
            $display("FAIL single_settle2: busy=%b required 1", oBusy);
        end
        tick();
        checks++;
        if (oBusy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_drop: busy=%b required 0", oBusy);
        end
        checks++;
        if (pushq.size() != 8 || cnt != 8) begin
            failures++;
            $display("FAIL single_fifo_count: bytes=%0d count=%0d required 8/8", pushq.size(), cnt);
        end
        pops = 4;
        for (int k = 0; k < 10 && pops > 0; k++) tick();
        checks++;
        if (cnt != 0) begin
            failures++;
            $display("FAIL single_words_out: count=%0d required 0 after 4 word reads", cnt);
        end
        reset_model(0);
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] g[4];
        int ng = 0;
        logic [8:0] exp_b;
        do_reset();
        base0 = 9'h020;
        base1 = 9'h120;
        dv0 = 1'b1;
        dv1 = 1'b1;
        iReq0Length = 5'd4;
        iReq1Length = 5'd4;
        iReq0Valid = 1'b1;
        iReq1Valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (oReqGrant !== 2'b00 && ng < 4) begin
                g[ng] = oReqGrant;
                ng++;
                if (ng == 3) begin
                    iReq0Valid = 1'b0;
                    iReq1Valid = 1'b0;
                end
            end
            checks++;
            if ((oReq0DataReady && oActiveId) || (oReq1DataReady && !oActiveId)) begin
                failures++;
                $display("FAIL contention_ready_owner: rdy=%b%b id=%b", oReq1DataReady, oReq0DataReady, oActiveId);
            end
        end
        checks++;
        if (ng != 3 || g[0] !== 2'b01 || g[1] !== 2'b10 || g[2] !== 2'b01) begin
            failures++;
            $display("FAIL contention_grants: n=%0d seq=%b,%b,%b required 3 01,10,01", ng, g[0], g[1], g[2]);
        end
        checks++;
        if (pushq.size() != 12) begin
            failures++;
            $display("FAIL contention_push_count: got %0d required 12", pushq.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                exp_b = (i / 4 == 1) ? 9'h120 + 9'(i % 4) : 9'h020 + 9'((i / 8) * 4 + i % 4);
                checks++;
                if (pushq[i] !== exp_b) begin
                    failures++;
                    $display("FAIL contention_byte%0d: got %h required %h", i, pushq[i], exp_b);
                end
            end
        end
        reset_model(0);
        tick();
    endtask

    task automatic test_room_gate();
        int n = 0;
        logic got = 1'b0;
        reset_model(120);
        base0 = 9'h040;
        dv0 = 1'b1;
        tick();
        iReq0Length = 5'd8;
        iReq0Valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (oReqGrant !== 2'b00 || oBusy !== 1'b0) begin
                failures++;
                $display("FAIL room_no_grant: grant=%b busy=%b required 00/0 at count %0d", oReqGrant, oBusy, cnt);
            end
        end
        pops = 1;
        for (int k = 0; k < 6 && !got; k++) begin
            tick();
            got = oReqGrant === 2'b01;
        end
        iReq0Valid = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL room_grant_after_pop: grant=%b required 01", oReqGrant);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (oPushEnable) n++;
        end
        checks++;
        if (n != 8 || cnt != 126) begin
            failures++;
            $display("FAIL room_pushes: pushes=%0d count=%0d required 8/126", n, cnt);
        end
        reset_model(0);
        tick();
    endtask

    task automatic test_odd_zero();
        logic got = 1'b0;
        base1 = 9'h150;
        dv1 = 1'b1;
        iReq1Length = 5'd7;
        iReq1Valid = 1'b1;
        for (int k = 0; k < 5 && !got; k++) begin
            tick();
            got = oReqGrant !== 2'b00;
        end
        iReq1Valid = 1'b0;
        checks++;
        if (oReqGrant !== 2'b10) begin
            failures++;
            $display("FAIL odd_grant: grant=%b required 10", oReqGrant);
        end
        for (int k = 0; k < 15; k++) tick();
        checks++;
        if (pushq.size() != 6) begin
            failures++;
            $display("FAIL odd_push_count: got %0d required 6", pushq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (pushq[i] !== 9'h150 + 9'(i)) begin
                    failures++;
                    $display("FAIL odd_byte%0d: got %h required %h", i, pushq[i], 9'h150 + 9'(i));
                end
            end
        end
        got = 1'b0;
        iReq1Length = 5'd0;
        iReq1Valid = 1'b1;
        for (int k = 0; k < 5 && !got; k++) begin
            tick();
            got = oReqGrant !== 2'b00;
        end
        iReq1Valid = 1'b0;
        checks++;
        if (oReqGrant !== 2'b10) begin
            failures++;
            $display("FAIL zero_grant: grant=%b required 10", oReqGrant);
        end
        tick();
        checks++;
        if (oBusy !== 1'b0 || oPushEnable !== 1'b0 || oReqGrant !== 2'b00 || oReq1DataReady !== 1'b0) begin
            failures++;
            $display("FAIL zero_back_idle: busy=%b en=%b grant=%b rdy1=%b required 0/0/00/0",
                     oBusy, oPushEnable, oReqGrant, oReq1DataReady);
        end
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (pushq.size() != 6) begin
            failures++;
            $display("FAIL zero_no_push: bytes=%0d required 6", pushq.size());
        end
        reset_model(0);
        tick();
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic got = 1'b0;
        base0 = 9'h060;
        dv0 = 1'b1;
        iReq0Length = 5'd8;
        iReq0Valid = 1'b1;
        for (int k = 0; k < 5 && !got; k++) begin
            tick();
            got = oReqGrant === 2'b01;
        end
        iReq0Valid = 1'b0;
        for (int k = 0; k < 10 && n < 3; k++) begin
            tick();
            if (oPushEnable) n++;
        end
        force_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (oReq0DataReady !== 1'b0 || oPushEnable !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_stall%0d: rdy0=%b en=%b required 0/0", k, oReq0DataReady, oPushEnable);
            end
        end
        force_full = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (oPushEnable) n++;
        end
        checks++;
        if (n != 8 || pushq.size() != 8) begin
            failures++;
            $display("FAIL backpressure_count: pushes=%0d bytes=%0d required 8/8", n, pushq.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (pushq[i] !== 9'h060 + 9'(i)) begin
                    failures++;
                    $display("FAIL backpressure_byte%0d: got %h required %h", i, pushq[i], 9'h060 + 9'(i));
                end
            end
        end
        reset_model(0);
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        logic got = 1'b0;
        base0 = 9'h070;
        dv0 = 1'b1;
        iReq0Length = 5'd8;
        iReq0Valid = 1'b1;
        for (int k = 0; k < 5 && !got; k++) begin
            tick();
            got = oReqGrant === 2'b01;
        end
        iReq0Valid = 1'b0;
        for (int k = 0; k < 10 && n < 3; k++) begin
            tick();
            if (oPushEnable) n++;
        end
        tick();
        iReset = 1'b0;
        pend_push = 1'b0;
        pend_acc0 = 1'b0;
        #1;
        checks++;
        if (oReqGrant !== 2'b00 || oReq0DataReady !== 1'b0 || oReq1DataReady !== 1'b0 ||
            oPushEnable !== 1'b0 || oPushData !== 9'h000 || oBusy !== 1'b0 || oActiveId !== 1'b0) begin
            failures++;
            $display("FAIL midreset_values: grant=%b rdy=%b%b push=%b data=%h busy=%b id=%b required all zero",
                     oReqGrant, oReq1DataReady, oReq0DataReady, oPushEnable, oPushData, oBusy, oActiveId);
        end
        checks++;
        if (pushq.size() != 3) begin
            failures++;
            $display("FAIL midreset_pushed: bytes=%0d required 3", pushq.size());
        end
        tick();
        iReset = 1'b1;
        reset_model(0);
        tick();
        got = 1'b0;
        iReq0Length = 5'd2;
        iReq1Length = 5'd2;
        iReq0Valid = 1'b1;
        iReq1Valid = 1'b1;
        for (int k = 0; k < 5 && !got; k++) begin
            tick();
            got = oReqGrant !== 2'b00;
        end
        iReq0Valid = 1'b0;
        iReq1Valid = 1'b0;
        checks++;
        if (oReqGrant !== 2'b01) begin
            failures++;
            $display("FAIL midreset_pointer: grant=%b required 01", oReqGrant);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_contention();
        test_room_gate();
        test_odd_zero();
        test_backpressure();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nsc_byte_push_arbiter.md
# nsc_byte_push_arbiter

- Shares the 9-bit push side of the 9-bit-write / 18-bit-read dual-clock FIFO between two byte-stream requesters.
- Requesters announce bursts; the block picks one round-robin and admits a burst only when the FIFO has room for all of it.
- The granted requester streams its bytes into the FIFO without interleaving, so every 18-bit read word is two bytes from one source.
- Sits in front of the 128x9 / 64x18 FIFO on the NAND-side datapath, on the same clock as both FIFO ports.

## Interface

Parameters:
- DepthBytes, 128, FIFO write-side capacity in 9-bit entries.
- LenWidth, 5, width of the burst-length fields in bytes (bursts up to 30 bytes).

Ports:
- iClock  in  1  sole clock for all logic and for both FIFO ports.
- iReset  in  1  asynchronous, active-low reset (low = reset).
- iReq0Valid / iReq1Valid  in  1 each  requester has a burst pending; held until granted.
- iReq0Length / iReq1Length  in  LenWidth each  burst length in bytes; sampled at grant.
- oReqGrant  out  2  one-hot, one-cycle pulse: bit i means requester i is accepted.
- iReq0Data / iReq1Data  in  9 each  byte-plus-flag data.
- iReq0DataValid / iReq1DataValid  in  1 each  data beat valid.
- oReq0DataReady / oReq1DataReady  out  1 each  beat accepted when valid and ready are both high.
- oPushData  out  9  to FIFO din.
- oPushEnable  out  1  to FIFO wr_en.
- iFifoFull  in  1  from FIFO full.
- iFifoDataCount  in  7  from FIFO wr_data_count.
- oBusy  out  1  high in any state other than IDLE.
- oActiveId  out  1  index of the last granted requester.

## Operation

States: IDLE, GRANT, STREAM, SETTLE.

Length handling:
- Effective length L = length field with bit 0 forced to 0, so bursts are always even.

Room check:
- Free = (DepthBytes-1) - iFifoDataCount, computed in 8 bits.
- Count 127 is treated as possibly full.
- A burst may be granted only when Free >= L.

Arbitration:
- A round-robin pointer selects the candidate requester.
- If only one requester is valid, it is the candidate.
- If both are valid, the pointer side is the candidate.
- No bypass: if the candidate does not fit, the arbiter waits and does not consider the other requester.
- On grant the pointer moves to the other requester.

State transitions:
- IDLE -> GRANT when the candidate is valid and fits. The block latches the id and L.
- GRANT: oReqGrant[id] = 1 for one cycle. Next state is STREAM, or IDLE directly if L = 0.
- STREAM:
  - oReq<id>DataReady = !iFifoFull. The other requester's ready stays 0.
  - oPushEnable = selected DataValid & !iFifoFull. oPushData = selected data. Both are combinational from registered state.
  - Each accepted beat decrements the remaining count.
  - The cycle in which the last beat is accepted moves to SETTLE.
- SETTLE: 2 cycles, so the FIFO write count reflects the burst's pushes. Then IDLE.

Boundary rules:
- Valid beats that arrive while iFifoFull = 1 are stalled, not dropped.
- The requester that is not granted never sees ready.
- iReqXValid deasserting before grant withdraws the request with no side effects.

## Timing

- Reset values: oReqGrant = 0, both DataReady = 0, oPushEnable = 0, oPushData = 0, oBusy = 0, oActiveId = 0, pointer = requester 0, state IDLE. Reset applies mid-burst with no completion; unpushed bytes are abandoned.
- Request to grant: request seen in IDLE at cycle t, oReqGrant at t+1, first ready at t+2.
- Streaming throughput: 1 byte per cycle when not full.
- Burst end to next grant: last beat at cycle c, SETTLE at c+1 and c+2, IDLE at c+3, earliest next grant at c+4.
- oBusy is registered: high from GRANT through SETTLE.

## Test plan

- Single burst: iReq0Valid with length 8, FIFO empty -> oReqGrant = 01 one cycle after the request is seen; 8 pushes on consecutive cycles with data in order; 4 words read out; oBusy low 3 cycles after the last push.
- Contention: both valid with length 4 each -> grants 01, then 10, then 01 in alternation; pushes never interleave between requesters; each granted burst produces 4 pushes.
- Room gate: preload 120 bytes (count 120, Free 7), request length 8 -> no grant. Pop 1 word (count 118, Free 9) -> grant follows; exactly 8 pushes.
- Odd and zero lengths: length 7 -> 6 bytes pushed. Length 0 -> grant pulse, no push, return to IDLE.
- Backpressure: force iFifoFull high mid-burst for 5 cycles -> ready and oPushEnable stay low for those 5 cycles; the burst completes afterwards with no byte lost or duplicated.
- Reset mid-burst: assert iReset low after 3 of 8 pushes -> all outputs return to reset values immediately; after release, a new request is granted with the pointer back at requester 0.
